master_read_burst: RTL and testbench

- Parametrised AXI4 read master. It is the burst-capable successor of the single-beat CPU read port.
- Accepts one CPU/cache read request of 1..MAX_BEATS words.
- Issues a single INCR burst, buffers every returned beat, flags bad responses, and stalls the CPU until the burst completes.
- Sits between the IM/DM-side fetch logic and the master port of the AXI interconnect.

---
 rtl/axi_master_pkg.sv | 21 ++
 rtl/master_read_burst_if.sv | 34 +++
 rtl/beat_buffer.sv | 37 +++
 rtl/master_read_burst.sv | 147 ++++++++++++++
 tb/tb_master_read_burst.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_master_pkg.sv
// Shared AXI read-master types: FSM state encoding, response/burst codes, size helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // ARSIZE encoding: log2 of the number of bytes in one beat.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/master_read_burst_if.sv
// AXI4 read-address and read-data channels between the burst master and the interconnect.
// Latency: n/a (wiring only).
// Backpressure: ARVALID/ARREADY and RVALID/RREADY handshakes carried unchanged.
interface master_read_burst_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]   ARID_M;
    logic [ADDR_W-1:0] ARADDR_M;
    logic [LEN_W-1:0]  ARLEN_M;
    logic [2:0]        ARSIZE_M;
    logic [1:0]        ARBURST_M;
    logic              ARVALID_M;
    logic              ARREADY_M;

    logic [ID_W-1:0]   RID_M;
    logic [DATA_W-1:0] RDATA_M;
    logic [1:0]        RRESP_M;
    logic              RLAST_M;
    logic              RVALID_M;
    logic              RREADY_M;

    modport master (
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
        input  ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
    );

    modport slave (
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
        output ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
    );
endinterface

// File: rtl/beat_buffer.sv
// DEPTH x DATA_W register file holding returned read beats, flattened onto one read port.
// Latency: write visible on rd_dat the cycle after wr_en; clear takes priority over write.
// Backpressure: none, accepts a write every cycle.
module beat_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_W-1:0]       wr_dat,
    output logic [DEPTH*DATA_W-1:0] rd_dat
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    // Slot storage: zeroed on reset or clear, otherwise one indexed slot written per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else if (clr) begin
            mem_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    mem_q[i] <= wr_dat;
                end
            end
        end
    end

    assign rd_dat = mem_q;

endmodule

// File: rtl/master_read_burst.sv
// AXI4 INCR read-burst master: one CPU request of 1..MAX_BEATS words, beats collected into a buffer.
// Latency: request -> ADDR (>=1) -> DATA (>=len+1) -> DONE; read_valid no earlier than len+3 cycles.
// Backpressure: CPU stalled via read_pause_cpu until DONE; DONE held while read_hold is high.
module master_read_burst
    import axi_master_pkg::*;
#(
    parameter int              ID_W       = 4,
    parameter logic [ID_W-1:0] MASTER_ID  = 4'b0001,
    parameter logic [ID_W-1:0] DEFAULT_ID = 4'b0010,
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              MAX_BEATS  = 4,
    parameter int              LEN_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_read_signal,
    input  logic [ADDR_W-1:0]           address,
    input  logic [LEN_W-1:0]            req_len,
    input  logic                        read_hold,
    output logic [MAX_BEATS*DATA_W-1:0] read_data,
    output logic                        read_valid,
    output logic                        read_err,
    output logic                        read_pause_cpu,
    master_read_burst_if.master         axi
);

    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic [LEN_W-1:0]   len_clamp;
    logic               take_req;
    logic               r_hs;
    logic               beat_fits;
    logic               beat_bad;
    logic               short_burst;

    // Requests longer than the buffer are shortened to fill it exactly.
    assign len_clamp   = ({1'b0, req_len} >= MAX_CNT) ? LEN_W'(MAX_BEATS - 1) : req_len;
    assign take_req    = (state_q == IDLE) && cpu_read_signal;
    assign r_hs        = (state_q == DATA) && axi.RVALID_M;
    // Beats past len+1 have no slot; they are dropped and flagged.
    assign beat_fits   = (cnt_q <= {1'b0, len_q});
    assign beat_bad    = (axi.RRESP_M != RESP_OKAY) || (axi.RID_M != MASTER_ID);
    // RLAST before the last expected beat: cnt_q is the index of the beat being accepted.
    assign short_burst = axi.RLAST_M && (cnt_q < {1'b0, len_q});

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and channel/CPU outputs decoded from the current state.
    always_comb begin
        state_d        = state_q;
        axi.ARVALID_M  = 1'b0;
        axi.RREADY_M   = 1'b0;
        axi.ARID_M     = DEFAULT_ID;
        read_valid     = 1'b0;
        read_pause_cpu = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_read_signal) begin
                    read_pause_cpu = 1'b1;
                    state_d        = ADDR;
                end
            end
            ADDR: begin
                axi.ARVALID_M  = 1'b1;
                axi.ARID_M     = MASTER_ID;
                read_pause_cpu = 1'b1;
                if (axi.ARREADY_M) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                axi.RREADY_M   = 1'b1;
                axi.ARID_M     = MASTER_ID;
                read_pause_cpu = 1'b1;
                if (axi.RVALID_M && axi.RLAST_M) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                read_valid = 1'b1;
                if (!read_hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, beat counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (take_req) begin
            addr_q <= address;
            len_q  <= len_clamp;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (r_hs) begin
            if (beat_fits) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (!beat_fits || beat_bad || short_burst) begin
                err_q <= 1'b1;
            end
        end
    end

    assign axi.ARADDR_M  = addr_q;
    assign axi.ARLEN_M   = len_q;
    assign axi.ARSIZE_M  = axi_size(DATA_W);
    assign axi.ARBURST_M = BURST_INCR;
    assign read_err      = err_q;

    beat_buffer #(
        .DEPTH  (MAX_BEATS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (take_req),
        .wr_en  (r_hs && beat_fits),
        .wr_idx (cnt_q[IDX_W-1:0]),
        .wr_dat (axi.RDATA_M),
        .rd_dat (read_data)
    );

endmodule

// File: tb/tb_master_read_burst.sv
// Randomised bench for master_read_burst: driver acts as CPU and AXI slave, monitors score results.
// Latency: expected read_valid cycle derived from AR wait and beat gaps.
// Backpressure: ARREADY delays, RVALID gaps and read_hold exercised.
module tb_master_read_burst;

    localparam int          MAXB     = 4;
    localparam int          DW       = 32;
    localparam logic [3:0]  MID      = 4'b0001;
    localparam logic [3:0]  DID      = 4'b0010;

    typedef struct {
        logic [MAXB*DW-1:0] data;
        logic               err;
        int                 lat;
        int                 c0;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
    } ar_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_read_signal;
    logic [31:0]        address;
    logic [3:0]         req_len;
    logic               read_hold;
    logic [MAXB*DW-1:0] read_data;
    logic               read_valid;
    logic               read_err;
    logic               read_pause_cpu;

    master_read_burst_if #(.ID_W(4), .ADDR_W(32), .DATA_W(DW), .LEN_W(4)) axi ();

    master_read_burst #(
        .ID_W(4), .MASTER_ID(MID), .DEFAULT_ID(DID), .ADDR_W(32),
        .DATA_W(DW), .MAX_BEATS(MAXB), .LEN_W(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_read_signal(cpu_read_signal),
        .address        (address),
        .req_len        (req_len),
        .read_hold      (read_hold),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .read_err       (read_err),
        .read_pause_cpu (read_pause_cpu),
        .axi            (axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    res_t res_q[$];
    ar_t  ar_q[$];

    // Per-transaction beat list handed to the driver.
    logic [31:0] b_dat  [0:7];
    logic [1:0]  b_resp [0:7];
    logic [3:0]  b_id   [0:7];
    int          b_gap  [0:7];
    int          n_b;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_data"},   read_data, '0);
        chk({nm, "_valid"},  read_valid, 0);
        chk({nm, "_err"},    read_err, 0);
        chk({nm, "_pause"},  read_pause_cpu, 0);
        chk({nm, "_arvalid"}, axi.ARVALID_M, 0);
        chk({nm, "_rready"}, axi.RREADY_M, 0);
        chk({nm, "_araddr"}, axi.ARADDR_M, 0);
        chk({nm, "_arlen"},  axi.ARLEN_M, 0);
        chk({nm, "_arid"},   axi.ARID_M, DID);
    endtask

    function automatic void set_beat(input int i, input logic [31:0] d, input logic [1:0] r,
                                     input logic [3:0] id, input int g);
        b_dat[i] = d; b_resp[i] = r; b_id[i] = id; b_gap[i] = g;
    endfunction

    // One complete transaction: reference result computed from the beat list, then driven.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] len,
                           input int ar_delay, input int hold);
        res_t r;
        int   eff;
        bit   got;
        eff    = (len >= MAXB) ? MAXB - 1 : int'(len);
        r.data = '0;
        r.err  = 1'b0;
        r.lat  = ar_delay + 2;
        for (int i = 0; i < n_b; i++) begin
            r.lat += b_gap[i] + 1;
            if (b_resp[i] != 2'b00 || b_id[i] != MID) r.err = 1'b1;
            if (i <= eff) r.data[i*DW +: DW] = b_dat[i];
            else          r.err = 1'b1;
        end
        if (n_b - 1 < eff) r.err = 1'b1;

        step();
        r.c0 = cyc;
        res_q.push_back(r);
        ar_q.push_back('{addr: addr, len: 4'(eff)});
        cpu_read_signal = 1'b1;
        address         = addr;
        req_len         = len;
        read_hold       = (hold > 0);
        @(negedge clk);
        chk("pause_on_req", read_pause_cpu, 1);
        step();
        cpu_read_signal = 1'b0;
        address         = $urandom;
        chk("err_cleared", read_err, 0);
        repeat (ar_delay) step();
        axi.ARREADY_M = 1'b1;
        step();
        axi.ARREADY_M = 1'b0;
        for (int i = 0; i < n_b; i++) begin
            axi.RVALID_M = 1'b0;
            axi.RLAST_M  = 1'b0;
            repeat (b_gap[i]) step();
            axi.RVALID_M = 1'b1;
            axi.RDATA_M  = b_dat[i];
            axi.RRESP_M  = b_resp[i];
            axi.RID_M    = b_id[i];
            axi.RLAST_M  = (i == n_b - 1);
            step();
        end
        axi.RVALID_M = 1'b0;
        axi.RLAST_M  = 1'b0;

        got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (read_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got read_valid=0 expected 1 within 40 cycles");
            read_hold = 1'b0;
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                chk("hold_valid", read_valid, 1);
                chk("hold_data", read_data, r.data);
            end
            read_hold = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("release_valid", read_valid, 0);
        end
    endtask

    // Result and AR-channel monitor, plus handshake-rule checks.
    logic        prev_v   = 1'b0;
    logic        ar_wait  = 1'b0;
    logic [31:0] ar_addr_prev;
    logic [3:0]  ar_len_prev;
    always @(negedge clk) begin
        if (!rst) begin
            prev_v  <= 1'b0;
            ar_wait <= 1'b0;
        end else begin
            if (read_valid && !prev_v) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    res_t e;
                    e = res_q.pop_front();
                    chk("result_data", read_data, e.data);
                    chk("result_err", read_err, e.err);
                    chk("result_latency", 128'(cyc - e.c0), 128'(e.lat));
                end
            end
            if (axi.ARVALID_M && axi.ARREADY_M) begin
                if (ar_q.size() == 0) begin
                    chk("unexpected_ar", 1'b1, 1'b0);
                end else begin
                    ar_t a;
                    a = ar_q.pop_front();
                    chk("araddr", axi.ARADDR_M, a.addr);
                    chk("arlen", axi.ARLEN_M, a.len);
                    chk("arid", axi.ARID_M, MID);
                    chk("arsize", axi.ARSIZE_M, 3'd2);
                    chk("arburst", axi.ARBURST_M, 2'b01);
                end
            end
            if (ar_wait) begin
                chk("arvalid_held", axi.ARVALID_M, 1);
                chk("araddr_stable", axi.ARADDR_M, ar_addr_prev);
                chk("arlen_stable", axi.ARLEN_M, ar_len_prev);
            end
            if (axi.ARVALID_M || axi.RREADY_M) begin
                chk("pause_busy", read_pause_cpu, 1);
                chk("no_valid_busy", read_valid, 0);
            end
            prev_v       <= read_valid;
            ar_wait      <= axi.ARVALID_M && !axi.ARREADY_M;
            ar_addr_prev <= axi.ARADDR_M;
            ar_len_prev  <= axi.ARLEN_M;
        end
    end

    initial begin
        int len, eff, mode, ard, hld;
        rst             = 1'b0;
        cpu_read_signal = 1'b0;
        address         = '0;
        req_len         = '0;
        read_hold       = 1'b0;
        axi.ARREADY_M   = 1'b0;
        axi.RVALID_M    = 1'b0;
        axi.RLAST_M     = 1'b0;
        axi.RDATA_M     = '0;
        axi.RRESP_M     = 2'b00;
        axi.RID_M       = MID;
        repeat (3) step();
        chk_reset("rst_init");
        rst = 1'b1;
        step();

        // Single beat, immediate ARREADY.
        n_b = 1;
        set_beat(0, 32'hDEAD_BEEF, 2'b00, MID, 0);
        run_txn(32'h0000_0010, 4'd0, 0, 0);

        // Four beats, ARREADY low 3 cycles, 2-cycle RVALID gaps.
        n_b = 4;
        for (int i = 0; i < 4; i++) set_beat(i, 32'(i + 1), 2'b00, MID, (i == 0) ? 0 : 2);
        run_txn(32'h0000_1000, 4'd3, 3, 0);

        // SLVERR on beat 2, then a clean request.
        for (int i = 0; i < 4; i++) set_beat(i, 32'hA0 + 32'(i), (i == 1) ? 2'b10 : 2'b00, MID, 0);
        run_txn(32'h0000_2000, 4'd3, 1, 0);
        for (int i = 0; i < 4; i++) set_beat(i, 32'hB0 + 32'(i), 2'b00, MID, 0);
        run_txn(32'h0000_2100, 4'd3, 0, 0);

        // Short burst: RLAST on beat 2 of 4.
        n_b = 2;
        for (int i = 0; i < 2; i++) set_beat(i, 32'hC0 + 32'(i), 2'b00, MID, 0);
        run_txn(32'h0000_3000, 4'd3, 0, 0);

        // Clamp to 4 beats and a 5th overflow beat before RLAST.
        n_b = 5;
        for (int i = 0; i < 5; i++) set_beat(i, 32'hD0 + 32'(i), 2'b00, MID, 0);
        run_txn(32'h0000_4000, 4'd7, 0, 0);

        // Wrong RID on a beat.
        n_b = 2;
        set_beat(0, 32'h1111_0000, 2'b00, MID, 0);
        set_beat(1, 32'h1111_0001, 2'b00, 4'b0101, 1);
        run_txn(32'h0000_5000, 4'd1, 2, 0);

        // DONE held for 5 cycles.
        n_b = 2;
        for (int i = 0; i < 2; i++) set_beat(i, 32'hE0 + 32'(i), 2'b00, MID, 0);
        run_txn(32'h0000_6000, 4'd1, 0, 5);

        // Reset mid-DATA: one beat in, then asynchronous reset.
        step();
        ar_q.push_back('{addr: 32'h0000_7000, len: 4'd3});
        cpu_read_signal = 1'b1;
        address         = 32'h0000_7000;
        req_len         = 4'd3;
        step();
        cpu_read_signal = 1'b0;
        axi.ARREADY_M   = 1'b1;
        step();
        axi.ARREADY_M   = 1'b0;
        axi.RVALID_M    = 1'b1;
        axi.RDATA_M     = 32'h7777_7777;
        axi.RRESP_M     = 2'b00;
        axi.RID_M       = MID;
        axi.RLAST_M     = 1'b0;
        step();
        axi.RVALID_M    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset("rst_mid");
        repeat (2) step();
        rst = 1'b1;
        step();

        // Recovery after reset.
        n_b = 3;
        for (int i = 0; i < 3; i++) set_beat(i, 32'hF0 + 32'(i), 2'b00, MID, 1);
        run_txn(32'h0000_8000, 4'd2, 1, 0);

        // Randomised transactions.
        for (int t = 0; t < 40; t++) begin
            len  = $urandom_range(0, 7);
            eff  = (len >= MAXB) ? MAXB - 1 : len;
            mode = $urandom_range(0, 9);
            if (mode == 0)      n_b = $urandom_range(1, eff + 1);
            else if (mode == 1) n_b = eff + 1 + $urandom_range(1, 2);
            else                n_b = eff + 1;
            for (int i = 0; i < n_b; i++) begin
                set_beat(i, $urandom,
                         ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                         ($urandom_range(0, 19) == 0) ? 4'b0011 : MID,
                         $urandom_range(0, 2));
            end
            ard = $urandom_range(0, 3);
            hld = $urandom_range(0, 3);
            run_txn($urandom & 32'hFFFF_FFF0, 4'(len), ard, hld);
        end

        repeat (3) step();
        chk("results_drained", 128'(res_q.size()), 0);
        chk("ar_drained", 128'(ar_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
